// File: rtl/snapshot_readout_if.sv
// Snapshot readout bus: capture-buffer read port plus AXI-stream sample output.
interface snapshot_readout_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/snapshot_readout.sv
// Streams snap_len samples from a capture buffer onto AXI-stream via a 2-deep FIFO.
// Define SNAPSHOT_READOUT_ABORT_EN to add the abort input.
module snapshot_readout #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
`ifdef SNAPSHOT_READOUT_ABORT_EN
    input  logic              abort,
`endif
    input  logic [CNT_W-1:0]  snap_len,
    input  logic [ADDR_W-1:0] base_addr,
    snapshot_readout_if.master bus,
    output logic              busy,
    output logic              readout_done,
    output logic [CNT_W-1:0]  rd_count_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
`ifdef SNAPSHOT_READOUT_ABORT_EN
        , S_ABORT
`endif
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  accepted;
    logic [ADDR_W-1:0] base_q;
    logic              inflight;
    logic              done_q;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              rd_en;
    logic              push;
    logic              pop;
    logic              flush;
    logic              load;
    logic              last_beat;
    logic              tvalid;
    logic [1:0]        occ;

    assign tvalid    = (count != 2'd0);
    assign pop       = tvalid && bus.m_axis_tready;
    assign last_beat = (accepted == len_q - CNT_W'(1));
    // Occupancy the FIFO will see once outstanding reads land.
    assign occ       = count + {1'b0, inflight} - {1'b0, pop};

    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        load    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load    = (snap_len != '0);
                    state_n = (snap_len != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                push  = inflight;
                rd_en = (issued < len_q) && (occ < 2'd2);
                if (rd_en && (issued + CNT_W'(1) == len_q))
                    state_n = S_DRAIN;
`ifdef SNAPSHOT_READOUT_ABORT_EN
                if (abort) begin
                    rd_en   = 1'b0;
                    state_n = S_ABORT;
                end
`endif
            end
            S_DRAIN: begin
                push = inflight;
                if (pop && last_beat)
                    state_n = S_DONE;
`ifdef SNAPSHOT_READOUT_ABORT_EN
                if (abort)
                    state_n = S_ABORT;
`endif
            end
            S_DONE: begin
                if (!start)
                    state_n = S_IDLE;
            end
`ifdef SNAPSHOT_READOUT_ABORT_EN
            // Let the presented beat complete, then throw the rest away.
            S_ABORT: begin
                if (!tvalid || pop) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            base_q   <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state    <= state_n;
            inflight <= rd_en;
            done_q   <= (state_n == S_DONE) && (state != S_DONE);
            if (load) begin
                len_q    <= snap_len;
                base_q   <= base_addr;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (rd_en)
                    issued <= issued + CNT_W'(1);
                if (pop)
                    accepted <= accepted + CNT_W'(1);
            end
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.mem_rd_data;
    end

    assign bus.mem_rd_en     = rd_en;
    assign bus.mem_rd_addr   = rd_en ? base_q + issued[ADDR_W-1:0] : '0;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tvalid ? fifo_mem[rd_ptr] : '0;
    assign bus.m_axis_tlast  = tvalid && last_beat;

    assign busy         = (state == S_READ) || (state == S_DRAIN);
    assign readout_done = done_q;
    assign rd_count_dbg = accepted;

endmodule

// File: tb/tb_snapshot_readout.sv
// Scoreboard bench for snapshot_readout: memory returns its own address as data.
module tb_snapshot_readout;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  snap_len = '0;
    logic [ADDR_W-1:0] base_addr = '0;
`ifdef SNAPSHOT_READOUT_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic              busy;
    logic              readout_done;
    logic [CNT_W-1:0]  rd_count_dbg;

    snapshot_readout_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    snapshot_readout #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
`ifdef SNAPSHOT_READOUT_ABORT_EN
        .abort       (abort),
`endif
        .snap_len    (snap_len),
        .base_addr   (base_addr),
        .bus         (bus),
        .busy        (busy),
        .readout_done(readout_done),
        .rd_count_dbg(rd_count_dbg)
    );

    always #5 sys_clk = ~sys_clk;

    // Buffer model: data == address, garbage when no read was issued.
    always @(posedge sys_clk)
        bus.mem_rd_data <= bus.mem_rd_en ? 16'(bus.mem_rd_addr) : 16'hDEAD;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                acc_cnt = 0;
    int                done_cnt = 0;
    int                tready_mode = 0;
    bit                lat_arm = 0;
    int                lat_start = 0;
    int                first_rd = -1;
    int                first_tv = -1;
    bit                hold_pend = 0;
    logic [DATA_W-1:0] held_data;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tready driver: 0 = always high, 1 = toggle, 2 = manual
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (tready_mode == 0)
                bus.m_axis_tready = 1'b1;
            else if (tready_mode == 1)
                bus.m_axis_tready = ~bus.m_axis_tready;
        end
    end

    // Monitor
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            hold_pend = 0;
        end else begin
            if (bus.mem_rd_en) begin
                if (lat_arm && first_rd < 0)
                    first_rd = cyc;
                if (addr_q.size() == 0)
                    check("unexpected_read", 1, 0);
                else
                    check("rd_addr", bus.mem_rd_addr, addr_q.pop_front());
            end
            if (bus.m_axis_tvalid) begin
                if (lat_arm && first_tv < 0)
                    first_tv = cyc;
                if (hold_pend)
                    check("stall_hold", bus.m_axis_tdata, held_data);
                if (bus.m_axis_tready) begin
                    hold_pend = 0;
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("tdata", bus.m_axis_tdata, e.data);
                        check("tlast", bus.m_axis_tlast, e.last);
                    end
                end else begin
                    hold_pend = 1;
                    held_data = bus.m_axis_tdata;
                end
            end else if (hold_pend) begin
                check("tvalid_dropped", 0, 1);
                hold_pend = 0;
            end
            if (readout_done)
                done_cnt++;
        end
    end

    task automatic launch(input logic [ADDR_W-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [ADDR_W-1:0] a;
            a = base + ADDR_W'(i);
            exp_q.push_back('{data: 16'(a), last: (i == len - 1)});
            addr_q.push_back(a);
        end
        @(posedge sys_clk);
        #1;
        start     = 1'b1;
        snap_len  = CNT_W'(len);
        base_addr = base;
        lat_start = cyc;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        check("done_seen", done_cnt != d0, 1);
    endtask

    task automatic wait_acc(input int target);
        int k;
        k = 0;
        while (acc_cnt < target && k < 200) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        check("acc_reached", acc_cnt >= target, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
        check({tag, "_tdata"}, bus.m_axis_tdata, 0);
        check({tag, "_tlast"}, bus.m_axis_tlast, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, readout_done, 0);
        check({tag, "_count"}, rd_count_dbg, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int a0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_idle_outputs("reset");
        sys_rst = 1'b0;

        // 8 beats from base 0, tready high, latency and tlast
        tready_mode = 0;
        d0 = done_cnt;
        first_rd = -1;
        first_tv = -1;
        lat_arm = 1;
        launch(10'd0, 8);
        wait_done(d0);
        lat_arm = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("t1_lat_rd", first_rd - lat_start, 1);
        check("t1_lat_tvalid", first_tv - lat_start, 3);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_beats_left", exp_q.size(), 0);
        check("t1_reads_left", addr_q.size(), 0);
        check("t1_rd_count", rd_count_dbg, 8);
        check("t1_busy", busy, 0);

        // 4 beats with tready toggling every cycle
        tready_mode = 1;
        d0 = done_cnt;
        launch(10'd0, 4);
        wait_done(d0);
        repeat (2) @(posedge sys_clk);
        #1;
        tready_mode = 0;
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_beats_left", exp_q.size(), 0);
        check("t2_rd_count", rd_count_dbg, 4);

        // Address wrap 1022,1023,0,1
        d0 = done_cnt;
        launch(10'd1022, 4);
        wait_done(d0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_beats_left", exp_q.size(), 0);
        check("t3_reads_left", addr_q.size(), 0);

        // Zero-length readout with start held high
        d0 = done_cnt;
        @(posedge sys_clk);
        #1;
        start    = 1'b1;
        snap_len = '0;
        repeat (6) @(posedge sys_clk);
        #1;
        check("t4_busy", busy, 0);
        start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("t4_done_once", done_cnt - d0, 1);
        check("t4_rd_count_kept", rd_count_dbg, 4);

        // Reset after 3 of 8 accepted, then a clean readout
        d0 = done_cnt;
        a0 = acc_cnt;
        launch(10'd100, 8);
        wait_acc(a0 + 3);
        sys_rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(negedge sys_clk);
        check_idle_outputs("t5_rst");
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (8) @(posedge sys_clk);
        #1;
        check("t5_no_done", done_cnt - d0, 0);
        launch(10'd200, 3);
        wait_done(d0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("t5_done_once", done_cnt - d0, 1);
        check("t5_beats_left", exp_q.size(), 0);
        check("t5_rd_count", rd_count_dbg, 3);

`ifdef SNAPSHOT_READOUT_ABORT_EN
        // Abort with a beat stalled: beats 0,1,2 only, no done pulse
        tready_mode = 2;
        bus.m_axis_tready = 1'b1;
        d0 = done_cnt;
        a0 = acc_cnt;
        launch(10'd0, 8);
        wait_acc(a0 + 2);
        @(posedge sys_clk);
        #1;
        bus.m_axis_tready = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        abort = 1'b1;
        @(posedge sys_clk);
        #1;
        abort = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        bus.m_axis_tready = 1'b1;
        repeat (8) @(posedge sys_clk);
        #1;
        check("t6_accepted", acc_cnt - a0, 3);
        check("t6_beats_left", exp_q.size(), 5);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_busy", busy, 0);
        exp_q.delete();
        addr_q.delete();
        tready_mode = 0;
        launch(10'd5, 2);
        wait_done(d0);
        repeat (2) @(posedge sys_clk);
        #1;
        check("t6_after_beats", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/snapshot_readout.md
SNAPSHOT_READOUT -- requirements
Module: snapshot_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter ADDR_W, default 10, capture-buffer address width.
REQ-003 SHALL have parameter CNT_W, default 32, length/counter width.
REQ-004 sys_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin readout (level sampled in IDLE).
REQ-007 snap_len  in  CNT_W  samples to read; sampled with start.
REQ-008 base_addr  in  ADDR_W  first buffer address; sampled with start.
REQ-009 mem_rd_en  out  1  buffer read strobe.
REQ-010 mem_rd_addr  out  ADDR_W  buffer read address.
REQ-011 mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 m_axis_tdata  out  DATA_W  output sample.
REQ-013 m_axis_tvalid  out  1  AXI-stream valid.
REQ-014 m_axis_tready  in  1  AXI-stream ready.
REQ-015 m_axis_tlast  out  1  high on final sample of a readout.
REQ-016 busy  out  1  high in READ or DRAIN.
REQ-017 readout_done  out  1  one-cycle completion pulse.
REQ-018 rd_count_dbg  out  CNT_W  beats accepted in current readout.

Function
REQ-019 States: IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: start=1 and snap_len>0 -> READ, latch snap_len/base_addr, clear counters; start=1 and snap_len=0 -> DONE with readout_done pulse, no reads, no beats.
REQ-021 READ: issue mem_rd_en while issued<snap_len and (FIFO occupancy + in-flight reads - pop this cycle) < 2; mem_rd_addr = base_addr + issued, modulo 2^ADDR_W (wrap, no error).
REQ-022 Returned data SHALL enter a 2-entry output FIFO; FIFO head drives m_axis_tdata/tvalid.
REQ-023 Latency: start high cycle 0 -> mem_rd_en cycle 1 -> m_axis_tvalid cycle 3 (tready held high).
REQ-024 Throughput SHALL be 1 beat/cycle while tready=1; no sample loss or duplication under any tready pattern.
REQ-025 Once tvalid asserted, tvalid and tdata SHALL hold until accepted.
REQ-026 READ -> DRAIN when issued reaches snap_len; DRAIN -> DONE on acceptance of beat snap_len-1.
REQ-027 m_axis_tlast SHALL be 1 only on beat index snap_len-1.
REQ-028 readout_done SHALL pulse the cycle after final beat acceptance.
REQ-029 DONE: wait for start=0, then IDLE; start ignored outside IDLE.
REQ-030 rd_count_dbg increments per accepted beat; cleared on entry to READ.

Reset
REQ-031 On sys_rst: state IDLE, FIFO empty, counters 0, all outputs 0, in-flight read data discarded.
REQ-032 Reset mid-readout SHALL drop tvalid next cycle; no readout_done pulse.

Configuration
REQ-033 Macro SNAPSHOT_READOUT_ABORT_EN: defined -> adds input abort (1 bit); abort=1 in READ/DRAIN stops new reads, beat currently presented (if any) stays until accepted, then FIFO and in-flight data flushed, state IDLE, no readout_done, tlast not forced; undefined -> no abort port, readouts always run to completion.

Verification
REQ-034 base_addr=0, snap_len=8, tready=1, memory holds addr -> 8 beats data 0..7 cycles 3..10, tlast on 7th index, readout_done once.
REQ-035 snap_len=4, tready toggling 1/0 every cycle -> data 0..3 in order, tdata stable while stalled, no duplicates.
REQ-036 base_addr=1022, snap_len=4, ADDR_W=10 -> reads addresses 1022,1023,0,1.
REQ-037 snap_len=0 -> no mem_rd_en, no tvalid, readout_done pulse; start held high keeps DONE until released.
REQ-038 sys_rst asserted after 3 accepted of 8 -> outputs 0 next cycle, next start reads cleanly from new base.
REQ-039 ABORT_EN: abort after 2 beats with tready=0 -> pending beat delivered once, then IDLE, no readout_done.
